// File: rtl/fp_div_seq.sv
// -----------------------------------------------------------------------------
// fp_div_seq -- sequential single-precision floating-point divider
//
// Divides a_in by b_in using a 26-step restoring mantissa divider, one step
// per clock. Special operands (zero/denormal exponent field, exponent 255) are
// resolved in a single CHECK cycle without running the divider.
//
// Latency (counted in rising edges after the edge that accepts start):
//   normal operands : done after 28 edges
//   special operands: done after 1 edge
//
// Ports
//   clk          in   1   rising-edge clock
//   reset        in   1   asynchronous, active-low reset
//   start        in   1   request, only looked at while idle
//   a_in         in  32   dividend, single-precision
//   b_in         in  32   divisor, single-precision
//   busy         out  1   high whenever the FSM is not idle
//   done         out  1   one-cycle pulse, result/flags valid
//   result       out 32   quotient {sign, exp[7:0], frac[22:0]}
//   overflow     out  1   exponent overflow or an operand with exponent 255
//   div_by_zero  out  1   divisor exponent field is 0
//
// Parameters
//   BIAS         exponent bias (127 for single precision)
//
// Build option
//   FPDIV_ROUND_EN  when defined, the quotient fraction is rounded by adding
//                   the guard bit; otherwise it is truncated. Latency is the
//                   same either way.
// -----------------------------------------------------------------------------
module fp_div_seq #(
  parameter int BIAS = 127
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        div_by_zero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    DIVIDE = 3'd2,
    NORM   = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic signed [9:0] BIAS_W     = 10'(BIAS);
  localparam logic [4:0]        LAST_ITER  = 5'd25;

  // State and datapath registers
  state_t             state_reg,    state_next;
  logic [31:0]        a_reg,        a_next;
  logic [31:0]        b_reg,        b_next;
  logic               sign_reg,     sign_next;
  logic signed [9:0]  exp_reg,      exp_next;
  // The remainder is kept below 2*div, so one bit above the 24-bit mantissa
  // is enough to hold it after the left shift.
  logic [24:0]        rem_reg,      rem_next;
  logic [23:0]        div_reg,      div_next;
  logic [25:0]        q_reg,        q_next;
  logic [4:0]         cnt_reg,      cnt_next;
  logic [31:0]        result_reg,   result_next;
  logic               overflow_reg, overflow_next;
  logic               dbz_reg,      dbz_next;

  // Operand fields of the captured inputs
  logic [7:0]         ea_w;
  logic [7:0]         eb_w;
  logic               sign_w;
  logic signed [9:0]  exp_calc_w;

  // Divider step
  logic               ge_w;
  logic [24:0]        rem_sub_w;

  // Normalisation
  logic [22:0]        frac_w;
  logic signed [9:0]  exp_norm_w;
`ifdef FPDIV_ROUND_EN
  logic               guard_w;
  logic [23:0]        frac_sum_w;
`endif

  assign ea_w       = a_reg[30:23];
  assign eb_w       = b_reg[30:23];
  assign sign_w     = a_reg[31] ^ b_reg[31];
  // Zero-extend the 8-bit exponents before subtracting so the difference is
  // a proper signed value; range is -126..380, well inside 10 bits.
  assign exp_calc_w = $signed({2'b00, ea_w}) - $signed({2'b00, eb_w}) + BIAS_W;

  assign ge_w       = (rem_reg >= {1'b0, div_reg});
  assign rem_sub_w  = rem_reg - {1'b0, div_reg};

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      sign_reg     <= 1'b0;
      exp_reg      <= '0;
      rem_reg      <= '0;
      div_reg      <= '0;
      q_reg        <= '0;
      cnt_reg      <= '0;
      result_reg   <= '0;
      overflow_reg <= 1'b0;
      dbz_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      sign_reg     <= sign_next;
      exp_reg      <= exp_next;
      rem_reg      <= rem_next;
      div_reg      <= div_next;
      q_reg        <= q_next;
      cnt_reg      <= cnt_next;
      result_reg   <= result_next;
      overflow_reg <= overflow_next;
      dbz_reg      <= dbz_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Quotient normalisation (only consumed in NORM)
  // ---------------------------------------------------------------------------
  always_comb begin
    frac_w     = '0;
    exp_norm_w = exp_reg;
`ifdef FPDIV_ROUND_EN
    guard_w    = 1'b0;
    frac_sum_w = '0;
`endif
    // q holds mant_a/mant_b scaled by 2^25, so its leading one is at bit 25
    // when mant_a >= mant_b and at bit 24 otherwise.
    if (q_reg[25]) begin
      frac_w     = q_reg[24:2];
      exp_norm_w = exp_reg;
`ifdef FPDIV_ROUND_EN
      guard_w    = q_reg[1];
`endif
    end else begin
      frac_w     = q_reg[23:1];
      exp_norm_w = exp_reg - 10'sd1;
`ifdef FPDIV_ROUND_EN
      guard_w    = q_reg[0];
`endif
    end
`ifdef FPDIV_ROUND_EN
    // Round up on the guard bit; a carry out of the fraction means the
    // mantissa became 2.0, i.e. fraction 0 with the exponent bumped.
    frac_sum_w = {1'b0, frac_w} + {23'd0, guard_w};
    if (frac_sum_w[23]) begin
      frac_w     = '0;
      exp_norm_w = exp_norm_w + 10'sd1;
    end else begin
      frac_w     = frac_sum_w[22:0];
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Next-state and datapath updates
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    a_next        = a_reg;
    b_next        = b_reg;
    sign_next     = sign_reg;
    exp_next      = exp_reg;
    rem_next      = rem_reg;
    div_next      = div_reg;
    q_next        = q_reg;
    cnt_next      = cnt_reg;
    result_next   = result_reg;
    overflow_next = overflow_reg;
    dbz_next      = dbz_reg;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          a_next     = a_in;
          b_next     = b_in;
          state_next = CHECK;
        end
      end

      CHECK: begin
        sign_next = sign_w;
        exp_next  = exp_calc_w;
        rem_next  = {2'b01, a_reg[22:0]};
        div_next  = {1'b1, b_reg[22:0]};
        q_next    = '0;
        cnt_next  = '0;
        // Special operands, highest priority first. Outputs are written here
        // directly since the divider is skipped.
        if (eb_w == 8'd0 && ea_w == 8'd0) begin
          result_next   = 32'h7FC0_0000;
          overflow_next = 1'b0;
          dbz_next      = 1'b1;
          state_next    = DONE;
        end else if (eb_w == 8'd0) begin
          result_next   = {sign_w, 8'hFF, 23'd0};
          overflow_next = 1'b0;
          dbz_next      = 1'b1;
          state_next    = DONE;
        end else if (ea_w == 8'hFF || eb_w == 8'hFF) begin
          result_next   = {sign_w, 8'hFF, 23'd0};
          overflow_next = 1'b1;
          dbz_next      = 1'b0;
          state_next    = DONE;
        end else if (ea_w == 8'd0) begin
          result_next   = {sign_w, 31'd0};
          overflow_next = 1'b0;
          dbz_next      = 1'b0;
          state_next    = DONE;
        end else begin
          state_next    = DIVIDE;
        end
      end

      DIVIDE: begin
        // One restoring step: compare/subtract, record the quotient bit,
        // then shift the partial remainder for the next bit.
        if (ge_w) begin
          q_next   = {q_reg[24:0], 1'b1};
          rem_next = rem_sub_w << 1;
        end else begin
          q_next   = {q_reg[24:0], 1'b0};
          rem_next = rem_reg << 1;
        end
        cnt_next = cnt_reg + 5'd1;
        if (cnt_reg == LAST_ITER) begin
          state_next = NORM;
        end
      end

      NORM: begin
        dbz_next = 1'b0;
        if (exp_norm_w >= 10'sd255) begin
          result_next   = {sign_reg, 8'hFF, 23'd0};
          overflow_next = 1'b1;
        end else if (exp_norm_w <= 10'sd0) begin
          result_next   = {sign_reg, 31'd0};
          overflow_next = 1'b0;
        end else begin
          result_next   = {sign_reg, exp_norm_w[7:0], frac_w};
          overflow_next = 1'b0;
        end
        state_next = DONE;
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);
  assign result      = result_reg;
  assign overflow    = overflow_reg;
  assign div_by_zero = dbz_reg;

endmodule

// File: tb/tb_fp_div_seq.sv
// -----------------------------------------------------------------------------
// tb_fp_div_seq -- directed, table-driven bench for fp_div_seq
//
// A table of operand pairs with hand-computed quotients, flags and latencies
// is applied one operation at a time; hand-written sequences then cover
// start re-pulsed while busy, back-to-back acceptance and reset mid-divide.
// Define FPDIV_ROUND_EN for both the bench and the design to check the
// rounded build.
// -----------------------------------------------------------------------------
module tb_fp_div_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a_in;
  logic [31:0] b_in;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        overflow;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;

  fp_div_seq #(.BIAS(127)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .a_in        (a_in),
    .b_in        (b_in),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow),
    .div_by_zero (div_by_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    logic        ov;
    logic        dz;
    int          lat;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs [NVEC];

`ifdef FPDIV_ROUND_EN
  localparam logic [31:0] THIRD     = 32'h3EAA_AAAB;
  localparam logic [31:0] TWO_THIRD = 32'h3F2A_AAAB;
`else
  localparam logic [31:0] THIRD     = 32'h3EAA_AAAA;
  localparam logic [31:0] TWO_THIRD = 32'h3F2A_AAAA;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issue one operation: hold start until the divider accepts it, then count
  // edges from the accepting edge until done (bounded at 60 edges).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        output int lat, output logic [31:0] res,
                        output logic ov, output logic dz);
    int n;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!busy && n < 5);
    start = 1'b0;
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = result;
    ov  = overflow;
    dz  = div_by_zero;
  endtask

  initial begin
    int          lat;
    logic [31:0] res;
    logic        ov;
    logic        dz;
    int          done_cnt;
    int          done_cyc;

    //           a             b             result        ov    dz    lat
    vecs[0]  = '{32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 1'b0, 1'b0, 28}; // 6/2
    vecs[1]  = '{32'h3F80_0000, 32'h4040_0000, THIRD,         1'b0, 1'b0, 28}; // 1/3
    vecs[2]  = '{32'h3F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1};  // 1/0
    vecs[3]  = '{32'h7F00_0000, 32'h3E80_0000, 32'h7F80_0000, 1'b1, 1'b0, 28}; // exp 256
    vecs[4]  = '{32'h0000_0000, 32'h0000_0000, 32'h7FC0_0000, 1'b0, 1'b1, 1};  // 0/0
    vecs[5]  = '{32'h7F80_0000, 32'h4000_0000, 32'h7F80_0000, 1'b1, 1'b0, 1};  // inf/2
    vecs[6]  = '{32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 1'b0, 1'b0, 1};  // -0/2
    vecs[7]  = '{32'hC000_0000, 32'h0000_0000, 32'hFF80_0000, 1'b0, 1'b1, 1};  // -2/0
    vecs[8]  = '{32'h7F80_0000, 32'h0000_0000, 32'h7F80_0000, 1'b0, 1'b1, 1};  // dz beats ov
    vecs[9]  = '{32'h4000_0000, 32'h7F80_0000, 32'h7F80_0000, 1'b1, 1'b0, 1};  // 2/inf
    vecs[10] = '{32'h0080_0000, 32'h4000_0000, 32'h0000_0000, 1'b0, 1'b0, 28}; // exp 0
    vecs[11] = '{32'h0080_0000, 32'h3FC0_0000, 32'h0000_0000, 1'b0, 1'b0, 28}; // exp 1-1
    vecs[12] = '{32'h3F80_0000, 32'h3FC0_0000, TWO_THIRD,     1'b0, 1'b0, 28}; // 1/1.5
    vecs[13] = '{32'h7F00_0000, 32'h3F00_0000, 32'h7F80_0000, 1'b1, 1'b0, 28}; // exp 255
    vecs[14] = '{32'h7F00_0000, 32'h3F80_0000, 32'h7F00_0000, 1'b0, 1'b0, 28}; // exp 254

    reset = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy",     {31'd0, busy},        32'd0);
    chk("reset done",     {31'd0, done},        32'd0);
    chk("reset result",   result,               32'd0);
    chk("reset overflow", {31'd0, overflow},    32'd0);
    chk("reset dbz",      {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i].a, vecs[i].b, lat, res, ov, dz);
      $display("vec %0d a=%h b=%h result=%h ov=%0b dz=%0b latency=%0d",
               i, vecs[i].a, vecs[i].b, res, ov, dz, lat);
      chk($sformatf("vec%0d result", i),   res,           vecs[i].res);
      chk($sformatf("vec%0d overflow", i), {31'd0, ov},   {31'd0, vecs[i].ov});
      chk($sformatf("vec%0d dbz", i),      {31'd0, dz},   {31'd0, vecs[i].dz});
      chk($sformatf("vec%0d latency", i),  32'(lat),      32'(vecs[i].lat));
    end

    // Back-to-back: start raised while done is high is ignored in DONE,
    // accepted in the following idle cycle.
    @(negedge clk);
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("b2b idle busy", {31'd0, busy}, 32'd0);
    chk("b2b idle done", {31'd0, done}, 32'd0);
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("b2b accepted", {31'd0, busy}, 32'd1);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk);
      #1;
      lat++;
    end
    $display("b2b a=40c00000 b=40000000 result=%h latency=%0d", result, lat);
    chk("b2b latency", 32'(lat), 32'd28);
    chk("b2b result",  result,   32'h4040_0000);

    // -1.5 / 0.5 with start re-pulsed while busy: exactly one done.
    @(negedge clk);
    @(negedge clk);
    a_in  = 32'hBFC0_0000;
    b_in  = 32'h3F00_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    done_cnt = 0;
    done_cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = (c == 3 || c == 10 || c == 20);
      if (c == 20) b_in = 32'h3F80_0000;
      @(posedge clk);
      #1;
      if (done) begin
        done_cnt++;
        done_cyc = c;
        chk("repulse result", result, 32'hC040_0000);
      end
    end
    start = 1'b0;
    $display("repulse a=bfc00000 b=3f000000 result=%h dones=%0d at=%0d",
             result, done_cnt, done_cyc);
    chk("repulse done count", 32'(done_cnt), 32'd1);
    chk("repulse done edge",  32'(done_cyc), 32'd28);
    chk("repulse hold",       result,        32'hC040_0000);

    // Reset during iteration 10 aborts the operation.
    @(negedge clk);
    a_in  = 32'h40C0_0000;
    b_in  = 32'h4000_0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort busy",     {31'd0, busy},        32'd0);
    chk("abort done",     {31'd0, done},        32'd0);
    chk("abort result",   result,               32'd0);
    chk("abort overflow", {31'd0, overflow},    32'd0);
    chk("abort dbz",      {31'd0, div_by_zero}, 32'd0);
    done_cnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) done_cnt++;
    end
    chk("abort no done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    run_op(32'h40C0_0000, 32'h4000_0000, lat, res, ov, dz);
    $display("after reset a=40c00000 b=40000000 result=%h latency=%0d", res, lat);
    chk("post reset latency", 32'(lat), 32'd28);
    chk("post reset result",  res,      32'h4040_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
